// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: accepts one stereo sample per frame over a
// valid/ready handshake and shifts it out on the codec DAC pin. LRCK and BCK
// are plain synchronous inputs that are edge-detected in the AUDIO_CLK domain.
//
// state | meaning
// SYNC  | idle after reset, output held 0, waiting for the first LRCK fall
// LEFT  | left slot active (LRCK low)
// RIGHT | right slot active (LRCK high)
module i2s_tx_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS  = 32,
  parameter int I2S_DELAY  = 1
) (
  input  logic                  AUDIO_CLK,
  input  logic                  iRST,
  input  logic                  iLRCK,
  input  logic                  iBCK,
  input  logic [DATA_WIDTH-1:0] iL_DATA,
  input  logic [DATA_WIDTH-1:0] iR_DATA,
  input  logic                  iVALID,
  output logic                  oREADY,
  output logic                  oDACDAT,
  output logic                  oFRAME_STB,
  output logic                  oUNDERRUN
);

  localparam int CW = $clog2(SLOT_BITS + 1);
  // Bit position k (1-based) carries data when DLY < k <= DEND.
  localparam logic [CW:0]   C_DLY  = (CW+1)'(I2S_DELAY);
  localparam logic [CW:0]   C_DEND = (CW+1)'(I2S_DELAY + DATA_WIDTH);
  localparam logic [CW-1:0] C_MAX  = CW'(SLOT_BITS);

  typedef enum logic [1:0] {ST_SYNC, ST_LEFT, ST_RIGHT} state_t;

  state_t                r_state;
  logic                  r_lr_q;
  logic                  r_bck_q;
  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_buf_l;
  logic [DATA_WIDTH-1:0] r_buf_r;
  logic [DATA_WIDTH-1:0] r_r_hold;
  logic [DATA_WIDTH-1:0] r_sh;
  logic [CW-1:0]         r_bitcnt;
  logic                  r_dacdat;
  logic                  r_frame_stb;
  logic                  r_underrun;

  logic                  w_bck_fall;
  logic                  w_lr_fall;
  logic                  w_lr_rise;
  logic                  w_write;
  logic                  w_slot_start;
  logic                  w_in_data;
  logic                  w_bit_out;
  logic [CW:0]           w_k;
  logic [DATA_WIDTH-1:0] w_new_word;

  assign w_bck_fall   = r_bck_q & ~iBCK;
  assign w_lr_fall    = r_lr_q & ~iLRCK;
  assign w_lr_rise    = ~r_lr_q & iLRCK;
  assign w_write      = iVALID & ~r_full;
  assign w_slot_start = w_lr_fall | (w_lr_rise & (r_state == ST_LEFT));

  // k of the BCK fall being processed in the current slot
  assign w_k       = {1'b0, r_bitcnt} + (CW+1)'(1);
  assign w_in_data = (w_k > C_DLY) && (w_k <= C_DEND);
  assign w_bit_out = (r_state != ST_SYNC) && w_in_data && r_sh[DATA_WIDTH-1];

  // Word entering the shifter: the buffered left word (or silence) at frame
  // load, the right word latched at that same load when the right slot opens.
  assign w_new_word = w_lr_fall ? (r_full ? r_buf_l : '0) : r_r_hold;

  assign oREADY     = ~r_full;
  assign oDACDAT    = r_dacdat;
  assign oFRAME_STB = r_frame_stb;
  assign oUNDERRUN  = r_underrun;

  // Edge-detect history; reset loads the live inputs so no edge appears on release
  always_ff @(posedge AUDIO_CLK) begin
    r_lr_q  <= iLRCK;
    r_bck_q <= iBCK;
  end

  // One-deep holding buffer between the engine handshake and frame load
  always_ff @(posedge AUDIO_CLK) begin
    if (iRST) begin
      r_full  <= 1'b0;
      r_buf_l <= '0;
      r_buf_r <= '0;
    end else if (w_write) begin
      r_full  <= 1'b1;
      r_buf_l <= iL_DATA;
      r_buf_r <= iR_DATA;
    end else if (w_lr_fall) begin
      r_full  <= 1'b0;
    end
  end

  // Slot sequencing, frame load and the registered serial output
  always_ff @(posedge AUDIO_CLK) begin
    if (iRST) begin
      r_state     <= ST_SYNC;
      r_r_hold    <= '0;
      r_sh        <= '0;
      r_bitcnt    <= '0;
      r_dacdat    <= 1'b0;
      r_frame_stb <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_frame_stb <= w_lr_fall;
      r_underrun  <= w_lr_fall & ~r_full;

      if (w_lr_fall) begin
        r_state  <= ST_LEFT;
        r_r_hold <= r_full ? r_buf_r : '0;
      end else if (w_lr_rise && (r_state == ST_LEFT)) begin
        r_state <= ST_RIGHT;
      end

      if (w_slot_start) begin
        r_bitcnt <= '0;
        if (I2S_DELAY == 0) begin
          // Left-justified: MSB goes out with the LRCK edge itself
          r_dacdat <= w_new_word[DATA_WIDTH-1];
          r_sh     <= w_new_word << 1;
        end else begin
          r_sh <= w_new_word;
          // A coincident BCK fall still closes out the old slot
          if (w_bck_fall) r_dacdat <= w_bit_out;
        end
      end else if (w_bck_fall) begin
        if (r_bitcnt != C_MAX) r_bitcnt <= r_bitcnt + CW'(1);
        r_dacdat <= w_bit_out;
        if (w_in_data) r_sh <= r_sh << 1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: clock-gen style LRCK/BCK (BCK = 6 clocks,
// LRCK half-period = 192 clocks), frame capture one sample per BCK period,
// and a bit-position model of the I2S / left-justified slot layout.
module tb_i2s_tx_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        lrck;
  logic        bck;
  logic [15:0] l0, r0;
  logic        v0;
  logic        rdy0, dat0, stb0, und0;
  logic [23:0] l1, r1;
  logic        v1;
  logic        rdy1, dat1, stb1, und1;

  int n_vec = 0;
  int n_bad = 0;
  int cyc;
  bit stream_on = 1'b0;
  bit xfer_pending = 1'b0;
  int seq;
  int xfers;

  logic [63:0] f0, f1;
  int          nstb, nund;
  logic        rdy_before, rdy_at_load;

  i2s_tx_serializer dut0 (
    .AUDIO_CLK(clk), .iRST(rst), .iLRCK(lrck), .iBCK(bck),
    .iL_DATA(l0), .iR_DATA(r0), .iVALID(v0),
    .oREADY(rdy0), .oDACDAT(dat0), .oFRAME_STB(stb0), .oUNDERRUN(und0)
  );

  i2s_tx_serializer #(.DATA_WIDTH(24), .SLOT_BITS(32), .I2S_DELAY(0)) dut1 (
    .AUDIO_CLK(clk), .iRST(rst), .iLRCK(lrck), .iBCK(bck),
    .iL_DATA(l1), .iR_DATA(r1), .iVALID(v1),
    .oREADY(rdy1), .oDACDAT(dat1), .oFRAME_STB(stb1), .oUNDERRUN(und1)
  );

  // Audio clock generator: LRCK high for cyc%384 < 192, BCK falls when cyc%6 == 0
  initial begin
    cyc  = 0;
    lrck = 1'b1;
    bck  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      lrck = ((cyc % 384) < 192) ? 1'b1 : 1'b0;
      bck  = ((cyc % 6) >= 3) ? 1'b1 : 1'b0;
    end
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected frame as seen by sampling the DAC pin once per BCK period.
  // Sample j = 0 follows the LRCK edge cycle, j = 1..31 follow each later BCK
  // fall; j = 32..63 is the right slot. The MSB lands on the (D+1)-th later
  // fall, or on the edge itself when D == 0; everything else is zero.
  function automatic logic [63:0] exp_frame(input logic [23:0] lw, input logic [23:0] rw,
                                            input int d, input int w);
    logic [63:0] f;
    int first;
    int idx;
    f = '0;
    first = (d == 0) ? 0 : d + 1;
    for (int j = 0; j < 32; j++) begin
      idx = j - first;
      if (idx >= 0 && idx < w) begin
        f[j]      = lw[w-1-idx];
        f[j + 32] = rw[w-1-idx];
      end
    end
    return f;
  endfunction

  function automatic logic [15:0] pat_l(input int s);
    return 16'h1000 + 16'(s);
  endfunction

  function automatic logic [15:0] pat_r(input int s);
    return 16'h8000 + 16'(s * 3);
  endfunction

  // Advance one clock; sample/drive 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (stream_on) begin
      if (xfer_pending) begin
        xfers++;
        seq++;
        l0 = pat_l(seq);
        r0 = pat_r(seq);
      end
      xfer_pending = v0 & rdy0;
    end
  endtask

  task automatic wait_to(input int v);
    int n;
    n = 0;
    while ((cyc % 384) != v && n < 1000) begin
      tick();
      n++;
    end
    if ((cyc % 384) != v) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_to: phase %0d not reached, at %0d", v, cyc % 384);
    end
  endtask

  // Capture one full frame starting at the next LRCK fall
  task automatic capture();
    f0 = '0;
    f1 = '0;
    nstb = 0;
    nund = 0;
    wait_to(191);
    rdy_before = rdy0;
    tick();
    xfers = 0;
    for (int c = 0; c < 384; c++) begin
      if (c == 0) begin
        rdy_at_load = rdy0;
        if (!stream_on) begin
          v0 = 1'b0;
          v1 = 1'b0;
        end
      end
      nstb += int'(stb0);
      nund += int'(und0);
      if ((c % 6) == 3) begin
        f0[c / 6] = dat0;
        f1[c / 6] = dat1;
      end
      if (c < 383) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0;
    l0 = '0; r0 = '0; l1 = '0; r1 = '0;
    repeat (4) tick();
    n_vec++;
    if ({dat0, rdy0, stb0, und0, dat1, rdy1, stb1, und1} !== 8'b0100_0100) begin
      n_bad++;
      $display("FAIL reset_held: got %b exp 01000100", {dat0, rdy0, stb0, und0, dat1, rdy1, stb1, und1});
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if ({dat0, rdy0, stb0, und0, dat1, rdy1, stb1, und1} !== 8'b0100_0100) begin
      n_bad++;
      $display("FAIL reset_release: got %b exp 01000100", {dat0, rdy0, stb0, und0, dat1, rdy1, stb1, und1});
    end
  endtask

  task automatic test_first_underrun();
    capture();
    n_vec++;
    if (nstb != 1 || nund != 1) begin
      n_bad++;
      $display("FAIL first_pulses: stb %0d und %0d exp 1 1", nstb, nund);
    end
    n_vec++;
    if (f0 !== 64'h0 || f1 !== 64'h0) begin
      n_bad++;
      $display("FAIL first_zero_frame: got %h %h exp 0 0", f0, f1);
    end
  endtask

  task automatic test_single_write();
    logic [63:0] e;
    wait_to(100);
    n_vec++;
    if (rdy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_idle: got %b exp 1", rdy0);
    end
    v0 = 1'b1; l0 = 16'hA5C3; r0 = 16'h1234;
    tick();
    v0 = 1'b0;
    n_vec++;
    if (rdy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_after_write: got %b exp 0", rdy0);
    end
    capture();
    e = exp_frame(24'hA5C3, 24'h1234, 1, 16);
    n_vec++;
    if (rdy_before !== 1'b0 || rdy_at_load !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_load_edge: before %b at_load %b exp 0 1", rdy_before, rdy_at_load);
    end
    n_vec++;
    if (f0 !== e) begin
      n_bad++;
      $display("FAIL a5c3_frame: got %h exp %h", f0, e);
    end
    n_vec++;
    if (nstb != 1 || nund != 0) begin
      n_bad++;
      $display("FAIL a5c3_pulses: stb %0d und %0d exp 1 0", nstb, nund);
    end
  endtask

  task automatic test_lrfall_valid();
    logic [15:0] lw, rw;
    logic [63:0] e;
    lw = 16'($urandom);
    rw = 16'($urandom);
    wait_to(191);
    v0 = 1'b1; l0 = lw; r0 = rw;
    capture();
    n_vec++;
    if (nund != 1 || f0 !== 64'h0 || rdy_at_load !== 1'b0) begin
      n_bad++;
      $display("FAIL lrfall_write_frame: und %0d frame %h rdy %b exp 1 0 0", nund, f0, rdy_at_load);
    end
    capture();
    e = exp_frame({8'h0, lw}, {8'h0, rw}, 1, 16);
    n_vec++;
    if (f0 !== e || nund != 0) begin
      n_bad++;
      $display("FAIL lrfall_next_frame: got %h und %0d exp %h und 0", f0, nund, e);
    end
  endtask

  task automatic test_stream();
    logic [63:0] e;
    wait_to(50);
    seq = 0;
    l0 = pat_l(0);
    r0 = pat_r(0);
    v0 = 1'b1;
    stream_on = 1'b1;
    xfer_pending = v0 & rdy0;
    for (int k = 0; k < 4; k++) begin
      capture();
      e = exp_frame({8'h0, pat_l(k)}, {8'h0, pat_r(k)}, 1, 16);
      n_vec++;
      if (f0 !== e || nund != 0 || xfers != 1) begin
        n_bad++;
        $display("FAIL stream_frame%0d: got %h und %0d xfers %0d exp %h 0 1", k, f0, nund, xfers, e);
      end
    end
    stream_on = 1'b0;
    v0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] lw, rw;
    logic [63:0] e;
    int nz;
    int n;
    lw = 16'($urandom);
    rw = 16'($urandom);
    wait_to(100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({dat0, rdy0} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %b exp 01", {dat0, rdy0});
    end
    nz = 0;
    n = 0;
    while ((cyc % 384) != 191 && n < 1000) begin
      tick();
      n++;
      nz += int'(dat0);
      if ((cyc % 384) == 150) begin
        v0 = 1'b1; l0 = lw; r0 = rw;
      end else begin
        v0 = 1'b0;
      end
    end
    n_vec++;
    if (nz != 0) begin
      n_bad++;
      $display("FAIL reset_mid_silence: %0d nonzero cycles exp 0", nz);
    end
    capture();
    e = exp_frame({8'h0, lw}, {8'h0, rw}, 1, 16);
    n_vec++;
    if (f0 !== e || nund != 0 || nstb != 1) begin
      n_bad++;
      $display("FAIL reset_mid_frame: got %h und %0d stb %0d exp %h 0 1", f0, nund, nstb, e);
    end
  endtask

  task automatic test_random();
    logic [63:0] e0, e1;
    for (int k = 0; k < 3; k++) begin
      wait_to(60);
      l0 = 16'($urandom); r0 = 16'($urandom);
      l1 = 24'($urandom); r1 = 24'($urandom);
      v0 = 1'b1; v1 = 1'b1;
      tick();
      v0 = 1'b0; v1 = 1'b0;
      e0 = exp_frame({8'h0, l0}, {8'h0, r0}, 1, 16);
      e1 = exp_frame(l1, r1, 0, 24);
      capture();
      n_vec++;
      if (f0 !== e0 || f1 !== e1 || nund != 0) begin
        n_bad++;
        $display("FAIL random%0d: got %h %h und %0d exp %h %h 0", k, f0, f1, nund, e0, e1);
      end
    end
  endtask

  task automatic test_d0_w24();
    logic [63:0] e;
    wait_to(60);
    l1 = 24'h800001;
    r1 = 24'($urandom);
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    e = exp_frame(l1, r1, 0, 24);
    capture();
    n_vec++;
    if (f1[31:0] !== 32'h0080_0001) begin
      n_bad++;
      $display("FAIL d0_left_800001: got %h exp 00800001", f1[31:0]);
    end
    n_vec++;
    if (f1 !== e) begin
      n_bad++;
      $display("FAIL d0_frame: got %h exp %h", f1, e);
    end
  endtask

  initial begin
    test_reset();
    test_first_underrun();
    test_single_write();
    test_lrfall_valid();
    test_stream();
    test_reset_mid();
    test_random();
    test_d0_w24();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
